// File: rtl/bus_receiver_pkg.sv
// Shared bus definitions: lane/word widths and the assembler state encoding.
// Used by bus_receiver, word_fifo and the bus_driver side of the link.
package bus_receiver_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic {
    IDLE      = 1'b0,
    HAVE_HIGH = 1'b1
  } asm_state_e;

endpackage

// File: rtl/bus_receiver_if.sv
// Byte-lane bus plus word-output stream between a bus driver/consumer
// (master) and bus_receiver (slave).
//   bushigh/buslow/enh/enl : byte lanes and their valids (master -> slave)
//   dout_ready             : consumer accept (master -> slave)
//   dout/dout_valid        : head-of-FIFO word (slave -> master)
//   count                  : words held in the FIFO (slave -> master)
//   overflow/frame_err     : one-cycle error pulses (slave -> master)
interface bus_receiver_if #(
  parameter int DEPTH = 4
) ();

  logic [7:0]              bushigh;
  logic [7:0]              buslow;
  logic                    enh;
  logic                    enl;
  logic [15:0]             dout;
  logic                    dout_valid;
  logic                    dout_ready;
  logic [$clog2(DEPTH):0]  count;
  logic                    overflow;
  logic                    frame_err;

  modport master (
    output bushigh, buslow, enh, enl, dout_ready,
    input  dout, dout_valid, count, overflow, frame_err
  );

  modport slave (
    input  bushigh, buslow, enh, enl, dout_ready,
    output dout, dout_valid, count, overflow, frame_err
  );

endinterface

// File: rtl/bus_receiver_word_fifo.sv
// word_fifo: DEPTH-entry first-in first-out word store with a registered
// head word.
//   clk, rst   : clock, asynchronous active-high reset
//   push/wdata : word offered this cycle
//   ready      : consumer accepts the head word when dout_valid is high
//   accepted   : the offered word is stored at this edge (combinational)
//   dout/dout_valid/count : registered head word, non-empty flag, occupancy
module word_fifo #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WORD_W-1:0]       wdata,
  input  logic                    ready,
  output logic                    accepted,
  output logic [WORD_W-1:0]       dout,
  output logic                    dout_valid,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [WORD_W-1:0] head_r;
  logic              valid_r;

  logic              pop_s;
  logic              accept_s;
  logic [PTR_W-1:0]  rd_ptr_nxt_s;
  logic [CNT_W-1:0]  left_s;
  logic [CNT_W-1:0]  count_nxt_s;
  logic [WORD_W-1:0] head_nxt_s;

  // Pop/push decisions and the word that becomes the head after this edge.
  always_comb begin
    pop_s        = valid_r & ready;
    // A full FIFO still accepts when the same edge frees a slot.
    accept_s     = push & ((count_r < FULL) | pop_s);
    rd_ptr_nxt_s = pop_s ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
    left_s       = pop_s ? count_r - CNT_W'(1) : count_r;
    count_nxt_s  = accept_s ? left_s + CNT_W'(1) : left_s;
    // Surviving words come from storage; an empty FIFO shows the
    // incoming word directly so it appears with one cycle of latency.
    if (left_s != '0) begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end else if (accept_s) begin
      head_nxt_s = wdata;
    end else begin
      head_nxt_s = '0;
    end
  end

  // Storage array, written at the tail on every accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (accept_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers (wrap modulo DEPTH), occupancy and registered head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      head_r   <= '0;
      valid_r  <= 1'b0;
    end else begin
      wr_ptr_r <= accept_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      head_r   <= head_nxt_s;
      valid_r  <= (count_nxt_s != '0);
    end
  end

  assign accepted   = accept_s;
  assign dout       = head_r;
  assign dout_valid = valid_r;
  assign count      = count_r;

endmodule

// File: rtl/bus_receiver.sv
// bus_receiver: assembles 16-bit words from separately-validated high and
// low byte lanes, queues them in word_fifo and flags lane-sequence errors
// and dropped words.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : bus_receiver_if slave modport (lanes in, words/status out)
module bus_receiver
  import bus_receiver_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  bus_receiver_if.slave   bus
);

  asm_state_e         state_r;
  asm_state_e         state_nxt_s;
  logic [BYTE_W-1:0]  held_r;
  logic [BYTE_W-1:0]  held_nxt_s;
  logic               complete_s;
  logic [WORD_W-1:0]  word_s;
  logic               frame_err_s;
  logic               frame_err_r;
  logic               overflow_r;
  logic               accepted_s;

  // Assembler next state, held byte, completed word and sequence errors.
  always_comb begin
    state_nxt_s = state_r;
    held_nxt_s  = held_r;
    complete_s  = 1'b0;
    word_s      = '0;
    frame_err_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.enh && !bus.enl) begin
          held_nxt_s  = bus.bushigh;
          state_nxt_s = HAVE_HIGH;
        end else if (bus.enh && bus.enl) begin
          complete_s = 1'b1;
          word_s     = {bus.bushigh, bus.buslow};
        end else if (bus.enl) begin
          frame_err_s = 1'b1;   // low byte with no high byte: discarded
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HAVE_HIGH: begin
        if (bus.enl && !bus.enh) begin
          complete_s  = 1'b1;
          word_s      = {held_r, bus.buslow};
          state_nxt_s = IDLE;
        end else if (bus.enh && !bus.enl) begin
          frame_err_s = 1'b1;   // second high byte replaces the held one
          held_nxt_s  = bus.bushigh;
        end else if (bus.enh && bus.enl) begin
          frame_err_s = 1'b1;   // held byte dropped, fresh pair completes
          complete_s  = 1'b1;
          word_s      = {bus.bushigh, bus.buslow};
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HAVE_HIGH;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Assembler state, held byte and registered error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      held_r      <= '0;
      frame_err_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      held_r      <= held_nxt_s;
      frame_err_r <= frame_err_s;
      overflow_r  <= complete_s & ~accepted_s;
    end
  end

  word_fifo #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (complete_s),
    .wdata      (word_s),
    .ready      (bus.dout_ready),
    .accepted   (accepted_s),
    .dout       (bus.dout),
    .dout_valid (bus.dout_valid),
    .count      (bus.count)
  );

  assign bus.frame_err = frame_err_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_bus_receiver.sv
module tb_bus_receiver;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bus_receiver_if #(.DEPTH(DEPTH)) b ();

  bus_receiver #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of words plus "is a high byte pending".
  logic [15:0] q[$];
  bit          m_have;
  logic [7:0]  m_held;
  bit          m_ferr;
  bit          m_ovf;
  bit          m_done;
  bit          m_pop;
  logic [15:0] m_word;
  int          m_size;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_have = 1'b0; m_held = 8'h00; m_ferr = 1'b0; m_ovf = 1'b0;
    end else begin
      m_done = 1'b0; m_word = 16'h0000; m_ferr = 1'b0; m_ovf = 1'b0;
      m_size = q.size();
      m_pop  = (m_size > 0) && b.dout_ready;
      if (b.enh && b.enl) begin
        m_ferr = m_have; m_done = 1'b1; m_word = {b.bushigh, b.buslow}; m_have = 1'b0;
      end else if (b.enh) begin
        m_ferr = m_have; m_held = b.bushigh; m_have = 1'b1;
      end else if (b.enl) begin
        if (m_have) begin
          m_done = 1'b1; m_word = {m_held, b.buslow}; m_have = 1'b0;
        end else begin
          m_ferr = 1'b1;
        end
      end
      if (m_pop) void'(q.pop_front());
      if (m_done) begin
        if (m_size < DEPTH || m_pop) q.push_back(m_word);
        else m_ovf = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_dout", 32'(b.dout), 32'h0);
      chk("rst_valid", 32'(b.dout_valid), 32'h0);
      chk("rst_count", 32'(b.count), 32'h0);
      chk("rst_flags", {30'h0, b.overflow, b.frame_err}, 32'h0);
    end else begin
      chk("valid", 32'(b.dout_valid), 32'(q.size() != 0));
      chk("count", 32'(b.count), 32'(q.size()));
      if (q.size() != 0) chk("dout", 32'(b.dout), 32'(q[0]));
      chk("frame_err", 32'(b.frame_err), 32'(m_ferr));
      chk("overflow", 32'(b.overflow), 32'(m_ovf));
    end
  end

  // Drive one cycle of lanes; outputs then reflect all earlier cycles.
  task automatic cyc(input logic h, input logic l, input logic [7:0] hi,
                     input logic [7:0] lo, input logic rdy);
    @(negedge clk);
    #1;
    b.enh = h; b.enl = l; b.bushigh = hi; b.buslow = lo; b.dout_ready = rdy;
  endtask

  initial begin
    b.enh = 1'b0; b.enl = 1'b0; b.bushigh = 8'h00; b.buslow = 8'h00; b.dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("lit_reset_valid", 32'(b.dout_valid), 32'h0);
    chk("lit_reset_dout", 32'(b.dout), 32'h0);
    chk("lit_reset_count", 32'(b.count), 32'h0);
    rst = 1'b0;

    // Split transfer
    cyc(1'b1, 1'b0, 8'hA5, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h00, 8'h3C, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("lit_split_dout", 32'(b.dout), 32'h0000A53C);
    chk("lit_split_valid", 32'(b.dout_valid), 32'h1);
    chk("lit_split_ferr", 32'(b.frame_err), 32'h0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("lit_split_gone", 32'(b.dout_valid), 32'h0);

    // Same-cycle transfer
    cyc(1'b1, 1'b1, 8'h12, 8'h34, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("lit_same_dout", 32'(b.dout), 32'h00001234);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    // Sequence errors
    cyc(1'b0, 1'b1, 8'h00, 8'h77, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("lit_lowonly_ferr", 32'(b.frame_err), 32'h1);
    chk("lit_lowonly_count", 32'(b.count), 32'h0);
    cyc(1'b1, 1'b0, 8'h11, 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 8'h22, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h00, 8'h33, 1'b1);
    chk("lit_dblhigh_ferr", 32'(b.frame_err), 32'h1);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("lit_dblhigh_ferr_end", 32'(b.frame_err), 32'h0);
    chk("lit_dblhigh_dout", 32'(b.dout), 32'h00002233);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    // Fill with consumer stalled: fifth word overflows
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b1, 8'(i), 8'(i), 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("lit_fill_count", 32'(b.count), 32'h4);
    chk("lit_fill_ovf", 32'(b.overflow), 32'h1);
    chk("lit_fill_head", 32'(b.dout), 32'h00000101);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("lit_fill_ovf_end", 32'(b.overflow), 32'h0);
    chk("lit_fill_stable", 32'(b.dout), 32'h00000101);

    // Full with simultaneous push and pop, across pointer wrap
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b1, 8'hAA, 8'(i), 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("lit_pp_count", 32'(b.count), 32'h4);
    chk("lit_pp_ovf", 32'(b.overflow), 32'h0);
    chk("lit_pp_head", 32'(b.dout), 32'h0000AA01);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("lit_drain_valid", 32'(b.dout_valid), 32'h0);

    // Reset while holding a high byte
    cyc(1'b1, 1'b0, 8'h99, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("lit_midrst_dout", 32'(b.dout), 32'h0);
    chk("lit_midrst_ferr", 32'(b.frame_err), 32'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 1'b1, 8'h00, 8'h55, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("lit_midrst_err", 32'(b.frame_err), 32'h1);
    chk("lit_midrst_noword", 32'(b.dout_valid), 32'h0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("lit_midrst_noword2", 32'(b.dout_valid), 32'h0);

    @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
